// File: rtl/phy_tx_serializer.sv
// PHY transmit serializer: samples one WIDTH-bit word per frame and shifts it out
// over LANES serial lanes, preceded by a fixed run of idle sync frames after reset.
module phy_tx_serializer #(
    parameter int               WIDTH       = 32,
    parameter int               LANES       = 1,
    parameter int               MSB_FIRST   = 1,
    parameter logic [WIDTH-1:0] IDLE_WORD   = 32'hBCBCBCBC,
    parameter int               SYNC_FRAMES = 4
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             load_ack,
    output logic [LANES-1:0] data_out,
    output logic             valid_out,
    output logic             frame_start,
    output logic             synced
);

    localparam int FRAME_LEN = WIDTH / LANES;
    localparam int BW        = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int SW        = (SYNC_FRAMES > 0) ? $clog2(SYNC_FRAMES + 1) : 1;
    localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_LEN - 1);
    localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_FRAMES);

    generate
        if ((WIDTH % LANES) != 0 || FRAME_LEN < 2) begin : g_bad_geometry
            $error("phy_tx_serializer: WIDTH must split into LANES lanes of at least 2 bits");
        end
        if (SYNC_FRAMES < 1) begin : g_bad_sync
            $error("phy_tx_serializer: SYNC_FRAMES must be at least 1");
        end
    endgenerate

    typedef enum logic {
        ST_SYNC   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [SW-1:0]    sync_cnt_q, sync_cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [LANES-1:0] data_out_q, data_out_d;
    logic             valid_out_q, valid_out_d;
    logic             frame_start_q, frame_start_d;
    logic             load_ack_q, load_ack_d;
    logic             synced_q, synced_d;

    logic             boundary;
    logic             accept;
    logic [WIDTH-1:0] load_word;
    logic [FRAME_LEN-1:0] seg;

    assign boundary = (bit_cnt_q == '0);

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_q       <= ST_SYNC;
            bit_cnt_q     <= '0;
            sync_cnt_q    <= '0;
            shift_q       <= '0;
            data_out_q    <= '0;
            valid_out_q   <= 1'b0;
            frame_start_q <= 1'b0;
            load_ack_q    <= 1'b0;
            synced_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            sync_cnt_q    <= sync_cnt_d;
            shift_q       <= shift_d;
            data_out_q    <= data_out_d;
            valid_out_q   <= valid_out_d;
            frame_start_q <= frame_start_d;
            load_ack_q    <= load_ack_d;
            synced_q      <= synced_d;
        end
    end

    // Frame bookkeeping: the only decisions are taken at boundary edges.
    always_comb begin
        state_d       = state_q;
        sync_cnt_d    = sync_cnt_q;
        bit_cnt_d     = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
        accept        = 1'b0;
        load_word     = IDLE_WORD;
        valid_out_d   = valid_out_q;
        frame_start_d = boundary;
        load_ack_d    = 1'b0;

        if (boundary) begin
            case (state_q)
                ST_SYNC: begin
                    // The frame after the last sync frame is already a data slot.
                    if (sync_cnt_q == SYNC_LAST) begin
                        state_d = ST_ACTIVE;
                        accept  = valid_in;
                    end else begin
                        sync_cnt_d = sync_cnt_q + 1'b1;
                    end
                end
                ST_ACTIVE: accept = valid_in;
                default:   state_d = ST_SYNC;
            endcase

            if (accept) begin
                load_word = data_in;
            end
            valid_out_d = accept;
            load_ack_d  = accept;
        end

        synced_d = (state_d == ST_ACTIVE);
    end

    // Per-lane shifter: the first bit is driven straight from the loaded word so it
    // appears right after the boundary edge; the remainder stays in shift_q.
    always_comb begin
        shift_d    = '0;
        data_out_d = '0;
        seg        = '0;
        for (int l = 0; l < LANES; l++) begin
            seg = boundary ? load_word[l*FRAME_LEN +: FRAME_LEN]
                           : shift_q[l*FRAME_LEN +: FRAME_LEN];
            if (MSB_FIRST != 0) begin
                data_out_d[l]                       = seg[FRAME_LEN-1];
                shift_d[l*FRAME_LEN +: FRAME_LEN]   = {seg[FRAME_LEN-2:0], 1'b0};
            end else begin
                data_out_d[l]                       = seg[0];
                shift_d[l*FRAME_LEN +: FRAME_LEN]   = {1'b0, seg[FRAME_LEN-1:1]};
            end
        end
    end

    assign data_out    = data_out_q;
    assign valid_out   = valid_out_q;
    assign frame_start = frame_start_q;
    assign load_ack    = load_ack_q;
    assign synced      = synced_q;

endmodule
